// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through data cache with true-LRU replacement.
// One-word lines; loads allocate on miss, stores write through without allocating.
module set_assoc_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL_REQ  = 3'd1,
    S_FILL_WAIT = 3'd2,
    S_WT_REQ    = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t state_r, state_nx;

  logic                  valid_r [SETS][WAYS];
  logic [TAG_W-1:0]      tag_r   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_r  [SETS][WAYS];
  logic [AGE_W-1:0]      age_r   [SETS][WAYS];

  logic [IDX_W-1:0]      req_idx_s;
  logic [TAG_W-1:0]      req_tag_s;
  logic [IDX_W-1:0]      lat_idx_s;
  logic [TAG_W-1:0]      lat_tag_s;
  logic                  hit_s;
  logic [AGE_W-1:0]      hit_way_s;
  logic [DATA_WIDTH-1:0] hit_data_s;
  logic [AGE_W-1:0]      victim_s;
  logic                  accept_s;
  logic                  fill_s;
  logic                  upd_en_s;
  logic [IDX_W-1:0]      upd_idx_s;
  logic [AGE_W-1:0]      upd_way_s;
  logic [AGE_W-1:0]      upd_age_s;
  logic                  unused_addr_lsb_s;

  assign req_idx_s = req_addr[IDX_W+1:2];
  assign req_tag_s = req_addr[ADDR_WIDTH-1:IDX_W+2];
  // The in-flight request address lives in mem_addr, so index/tag are recovered from it.
  assign lat_idx_s = mem_addr[IDX_W+1:2];
  assign lat_tag_s = mem_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_addr_lsb_s = ^req_addr[1:0];

  assign accept_s = req_valid & (state_r == S_IDLE);
  assign fill_s   = mem_resp_valid & (state_r == S_FILL_WAIT);

  // Tag compare across all ways of the requested set.
  always_comb begin
    hit_s      = 1'b0;
    hit_way_s  = {AGE_W{1'b0}};
    hit_data_s = {DATA_WIDTH{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s  = (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) ? AGE_W'(w) : hit_way_s;
      hit_data_s = (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) ? data_r[req_idx_s][w] : hit_data_s;
      hit_s      = hit_s | (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s));
    end
  end

  // Victim choice: lowest invalid way wins, otherwise the oldest way.
  always_comb begin
    victim_s = {AGE_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      victim_s = (age_r[lat_idx_s][w] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : victim_s;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = (!valid_r[lat_idx_s][w]) ? AGE_W'(w) : victim_s;
    end
  end

  // Select which set/way gets promoted to MRU this cycle.
  always_comb begin
    upd_en_s  = (accept_s & hit_s) | fill_s;
    upd_idx_s = fill_s ? lat_idx_s : req_idx_s;
    upd_way_s = fill_s ? victim_s : hit_way_s;
    upd_age_s = age_r[upd_idx_s][upd_way_s];
  end

  // Valid bits and LRU ages; younger-than-promoted ways each age by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          age_r[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (fill_s) begin
        valid_r[lat_idx_s][victim_s] <= 1'b1;
      end
      if (upd_en_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == upd_way_s) begin
            age_r[upd_idx_s][w] <= {AGE_W{1'b0}};
          end else if (age_r[upd_idx_s][w] < upd_age_s) begin
            age_r[upd_idx_s][w] <= age_r[upd_idx_s][w] + AGE_W'(1);
          end
        end
      end
    end
  end

  // Tag/data storage; contents are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[lat_idx_s][victim_s]  <= lat_tag_s;
      data_r[lat_idx_s][victim_s] <= mem_rdata;
    end else if (accept_s && req_we && hit_s) begin
      data_r[req_idx_s][hit_way_s] <= req_wdata;
    end
  end

  // Next-state logic for the request/miss/write-through sequence.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            state_nx = S_WT_REQ;
          end else if (hit_s) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_FILL_REQ;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_FILL_REQ: begin
        if (mem_req_ready) begin
          state_nx = S_FILL_WAIT;
        end else begin
          state_nx = S_FILL_REQ;
        end
      end
      S_FILL_WAIT: begin
        if (mem_resp_valid) begin
          state_nx = S_RESP;
        end else begin
          state_nx = S_FILL_WAIT;
        end
      end
      S_WT_REQ: begin
        if (mem_req_ready) begin
          state_nx = S_RESP;
        end else begin
          state_nx = S_WT_REQ;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and registered outputs; request fields are captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= {DATA_WIDTH{1'b0}};
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= {ADDR_WIDTH{1'b0}};
      mem_wdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r       <= state_nx;
      req_ready     <= (state_nx == S_IDLE);
      resp_valid    <= (state_nx == S_RESP);
      mem_req_valid <= (state_nx == S_FILL_REQ) || (state_nx == S_WT_REQ);
      if (accept_s) begin
        mem_we     <= req_we;
        mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata  <= req_wdata;
        resp_hit   <= hit_s;
        resp_rdata <= req_we ? {DATA_WIDTH{1'b0}} : hit_data_s;
      end else if (fill_s) begin
        resp_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized + directed bench for set_assoc_cache: a 2-way/8-set and a 4-way/4-set
// instance checked against a recency-list cache model and a backing-memory map.
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_hit [2];
  logic        mem_req_valid [2];
  logic        mem_req_ready [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic        mem_resp_valid [2];
  logic [31:0] mem_rdata [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model: per (dut,set) a list of resident tags, most recent first; word memory by {dut,addr}.
  int unsigned lru_q [16][$];
  logic [31:0] bmem [logic [32:0]];

  always #5 clk = ~clk;

  set_assoc_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAYS(2), .SETS(8)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_hit(resp_hit[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_resp_valid(mem_resp_valid[0]), .mem_rdata(mem_rdata[0])
  );

  set_assoc_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAYS(4), .SETS(4)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_hit(resp_hit[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_resp_valid(mem_resp_valid[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) lru_q[i].delete();
  endtask

  task automatic check_reset_outputs(input int d);
    check_eq("rst_resp_valid", resp_valid[d], 32'd0);
    check_eq("rst_resp_rdata", resp_rdata[d], 32'd0);
    check_eq("rst_resp_hit", resp_hit[d], 32'd0);
    check_eq("rst_mem_req_valid", mem_req_valid[d], 32'd0);
    check_eq("rst_mem_we", mem_we[d], 32'd0);
    check_eq("rst_mem_addr", mem_addr[d], 32'd0);
    check_eq("rst_mem_wdata", mem_wdata[d], 32'd0);
  endtask

  task automatic reset_dut();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_reset_outputs(d);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_eq("rst_req_ready", req_ready[d], 32'd1);
  endtask

  // One complete request on dut d, with memory handshake delays; checks every cycle.
  task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int rdy_dly, input int resp_dly, output bit got_hit);
    int idxw, ways, qi, pos;
    int unsigned tag;
    logic [31:0] waddr, mem_val;
    logic [32:0] key;
    bit exp_hit;
    idxw  = (d == 0) ? 3 : 2;
    ways  = (d == 0) ? 2 : 4;
    waddr = {addr[31:2], 2'b00};
    qi    = d * 8 + int'((addr >> 2) & ((32'd1 << idxw) - 32'd1));
    tag   = addr >> (idxw + 2);
    pos   = -1;
    for (int i = 0; i < lru_q[qi].size(); i++) if (lru_q[qi][i] == tag) pos = i;
    exp_hit = (pos >= 0);
    key = {d[0], waddr};
    if (!bmem.exists(key)) bmem[key] = $urandom;
    mem_val = bmem[key];
    if (exp_hit) begin
      lru_q[qi].delete(pos);
      lru_q[qi].push_front(tag);
    end else if (!we) begin
      if (lru_q[qi].size() == ways) void'(lru_q[qi].pop_back());
      lru_q[qi].push_front(tag);
    end
    if (we) bmem[key] = wdata;
    got_hit = 1'b0;

    @(negedge clk);
    check_eq("req_ready_idle", req_ready[d], 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    @(negedge clk);
    req_valid[d] = 1'b0;
    if (!we && exp_hit) begin
      check_eq("ldhit_resp_valid", resp_valid[d], 32'd1);
      check_eq("ldhit_resp_hit", resp_hit[d], 32'd1);
      check_eq("ldhit_rdata", resp_rdata[d], mem_val);
      check_eq("ldhit_no_mem", mem_req_valid[d], 32'd0);
      got_hit = resp_hit[d];
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check_eq("mreq_valid", mem_req_valid[d], 32'd1);
        check_eq("mreq_we", mem_we[d], {31'd0, we});
        check_eq("mreq_addr", mem_addr[d], waddr);
        if (we) check_eq("mreq_wdata", mem_wdata[d], wdata);
        check_eq("mreq_no_resp", resp_valid[d], 32'd0);
        if (i < rdy_dly) @(negedge clk);
      end
      mem_req_ready[d] = 1'b1;
      @(negedge clk);
      mem_req_ready[d] = 1'b0;
      check_eq("mreq_dropped", mem_req_valid[d], 32'd0);
      if (we) begin
        check_eq("st_resp_valid", resp_valid[d], 32'd1);
        check_eq("st_resp_hit", resp_hit[d], {31'd0, exp_hit});
        check_eq("st_rdata_zero", resp_rdata[d], 32'd0);
        got_hit = resp_hit[d];
      end else begin
        for (int j = 0; j < resp_dly; j++) begin
          check_eq("fill_wait_no_resp", resp_valid[d], 32'd0);
          @(negedge clk);
        end
        mem_resp_valid[d] = 1'b1;
        mem_rdata[d] = mem_val;
        @(negedge clk);
        mem_resp_valid[d] = 1'b0;
        mem_rdata[d] = $urandom;
        check_eq("fill_resp_valid", resp_valid[d], 32'd1);
        check_eq("fill_resp_hit", resp_hit[d], 32'd0);
        check_eq("fill_rdata", resp_rdata[d], mem_val);
        got_hit = resp_hit[d];
      end
    end
    @(negedge clk);
    check_eq("resp_one_cycle", resp_valid[d], 32'd0);
    check_eq("back_to_idle", req_ready[d], 32'd1);
  endtask

  initial begin
    bit h;
    logic [3:0] mask;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      mem_req_ready[d] = 1'b0; mem_resp_valid[d] = 1'b0; mem_rdata[d] = 32'd0;
    end
    reset_dut();

    // Cold miss then hit.
    bmem[{1'b0, 32'h0000_0040}] = 32'hDEAD_BEEF;
    txn(0, 1'b0, 32'h0000_0040, 32'd0, 0, 0, h); check_eq("cold_miss", h, 32'd0);
    txn(0, 1'b0, 32'h0000_0040, 32'd0, 0, 0, h); check_eq("warm_hit", h, 32'd1);

    // LRU eviction in set 0 of the 2-way cache.
    reset_dut();
    txn(0, 1'b0, 32'h00, 32'd0, 0, 0, h); check_eq("lru_a", h, 32'd0);
    txn(0, 1'b0, 32'h20, 32'd0, 0, 1, h); check_eq("lru_b", h, 32'd0);
    txn(0, 1'b0, 32'h00, 32'd0, 0, 0, h); check_eq("lru_a_hit", h, 32'd1);
    txn(0, 1'b0, 32'h40, 32'd0, 1, 0, h); check_eq("lru_c", h, 32'd0);
    txn(0, 1'b0, 32'h00, 32'd0, 0, 0, h); check_eq("lru_a_kept", h, 32'd1);
    txn(0, 1'b0, 32'h20, 32'd0, 0, 0, h); check_eq("lru_b_evicted", h, 32'd0);

    // Store hit/miss with write-through.
    txn(0, 1'b0, 32'h40, 32'd0, 0, 0, h);
    txn(0, 1'b1, 32'h40, 32'h1234_5678, 0, 0, h); check_eq("st_hit", h, 32'd1);
    txn(0, 1'b0, 32'h40, 32'd0, 0, 0, h); check_eq("st_then_ld_hit", h, 32'd1);
    txn(0, 1'b1, 32'h80, 32'hCAFE_0080, 0, 0, h); check_eq("st_miss", h, 32'd0);
    txn(0, 1'b0, 32'h80, 32'd0, 0, 0, h); check_eq("st_no_alloc", h, 32'd0);

    // Long ready stall, then a spurious fill response while idle.
    txn(0, 1'b0, 32'h104, 32'd0, 5, 2, h); check_eq("stall_miss", h, 32'd0);
    mem_resp_valid[0] = 1'b1; mem_rdata[0] = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_resp_valid[0] = 1'b0;
    check_eq("spurious_no_resp", resp_valid[0], 32'd0);
    check_eq("spurious_no_mreq", mem_req_valid[0], 32'd0);
    check_eq("spurious_ready", req_ready[0], 32'd1);
    txn(0, 1'b0, 32'h104, 32'd0, 0, 0, h); check_eq("spurious_data_kept", h, 32'd1);

    // 4-way: five tags into set 1 evict the first; ages stay a permutation.
    reset_dut();
    for (int t = 0; t < 5; t++) begin
      txn(1, 1'b0, 32'(t * 16 + 4), 32'd0, 0, 0, h); check_eq("w4_fill_miss", h, 32'd0);
    end
    mask = 4'd0;
    for (int w = 0; w < 4; w++) mask = mask | (4'd1 << dut1.age_r[1][w]);
    check_eq("w4_age_perm", {28'd0, mask}, 32'h0000_000F);
    txn(1, 1'b0, 32'h44, 32'd0, 0, 0, h); check_eq("w4_last_hit", h, 32'd1);
    txn(1, 1'b0, 32'h04, 32'd0, 0, 0, h); check_eq("w4_first_evicted", h, 32'd0);

    // Reset during FILL_WAIT drops the transaction.
    reset_dut();
    txn(0, 1'b0, 32'h40, 32'd0, 0, 0, h);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'hC0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    mem_req_ready[0] = 1'b1;
    @(negedge clk);
    mem_req_ready[0] = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    mem_resp_valid[0] = 1'b1; mem_rdata[0] = 32'h5555_AAAA;
    @(negedge clk);
    mem_resp_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("post_rst_no_resp", resp_valid[0], 32'd0);
      check_eq("post_rst_no_mreq", mem_req_valid[0], 32'd0);
      @(negedge clk);
    end
    txn(0, 1'b0, 32'h40, 32'd0, 0, 0, h); check_eq("post_rst_miss", h, 32'd0);

    // Randomized traffic on both geometries.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        int idxw;
        logic [31:0] a;
        idxw = (d == 0) ? 3 : 2;
        a = (32'($urandom_range(0, 5)) << (idxw + 2))
          | (32'($urandom_range(0, (1 << idxw) - 1)) << 2)
          | 32'($urandom_range(0, 3));
        txn(d, ($urandom_range(0, 3) == 0), a, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), h);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
